// File: rtl/and_delay_checker.sv
// Monitor for a transport-delay AND path: builds golden a&b delayed by DELAY cycles and
// checks it against dut_out. Define AND_DELAY_LAT_MEAS_EN to add first-edge latency measurement.
module and_delay_checker #(
    parameter int DELAY = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    input  logic             dut_out,
    output logic             busy,
    output logic             mismatch,
    output logic             err,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt
`ifdef AND_DELAY_LAT_MEAS_EN
    ,
    output logic [3:0]       lat_cyc,
    output logic             lat_vld
`endif
);

    typedef enum logic [1:0] {IDLE, FILL, CHECK} state_t;

    localparam logic [3:0] DELAY_L = 4'(DELAY);

    state_t           state;
    logic [DELAY-1:0] pipe;
    logic [DELAY:0]   pipe_ext;
    logic [3:0]       fill_cnt;
    logic             ab;
    logic             golden;

`ifdef AND_DELAY_LAT_MEAS_EN
    logic             lat_run;
    logic [3:0]       lat_cnt;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign ab       = a & b;
    assign pipe_ext = {pipe, ab};
    assign golden   = pipe[DELAY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pipe     <= '0;
            fill_cnt <= '0;
            busy     <= 1'b0;
            mismatch <= 1'b0;
            err      <= 1'b0;
            chk_cnt  <= '0;
            err_cnt  <= '0;
`ifdef AND_DELAY_LAT_MEAS_EN
            lat_run  <= 1'b0;
            lat_cnt  <= '0;
            lat_cyc  <= '0;
            lat_vld  <= 1'b0;
`endif
        end else begin
            mismatch <= 1'b0;
            if (!en) begin
                // Leaving a run: pipeline is flushed but results stay readable.
                state    <= IDLE;
                busy     <= 1'b0;
                pipe     <= '0;
                fill_cnt <= '0;
`ifdef AND_DELAY_LAT_MEAS_EN
                lat_run  <= 1'b0;
`endif
            end else begin
                pipe <= pipe_ext[DELAY-1:0];
                busy <= 1'b1;
                case (state)
                    IDLE: begin
                        fill_cnt <= 4'd1;
                        state    <= (DELAY_L == 4'd1) ? CHECK : FILL;
                        err      <= 1'b0;
                        chk_cnt  <= '0;
                        err_cnt  <= '0;
`ifdef AND_DELAY_LAT_MEAS_EN
                        lat_run  <= 1'b0;
                        lat_cnt  <= '0;
                        lat_cyc  <= '0;
                        lat_vld  <= 1'b0;
`endif
                    end
                    FILL: begin
                        fill_cnt <= fill_cnt + 4'd1;
                        if (fill_cnt + 4'd1 == DELAY_L) begin
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        chk_cnt <= sat_inc(chk_cnt);
                        if (dut_out != golden) begin
                            err_cnt  <= sat_inc(err_cnt);
                            mismatch <= 1'b1;
                            err      <= 1'b1;
                        end
`ifdef AND_DELAY_LAT_MEAS_EN
                        // pipe[0] holds the previous sample, so ab && !pipe[0] is a rising edge.
                        if (lat_run) begin
                            if (dut_out) begin
                                lat_cyc <= lat_cnt + 4'd1;
                                lat_vld <= 1'b1;
                                lat_run <= 1'b0;
                            end else if (lat_cnt == 4'd14) begin
                                lat_cyc <= 4'd15;
                                lat_vld <= 1'b1;
                                lat_run <= 1'b0;
                                err     <= 1'b1;
                            end else begin
                                lat_cnt <= lat_cnt + 4'd1;
                            end
                        end else if (!lat_vld && ab && !pipe[0]) begin
                            lat_run <= 1'b1;
                            lat_cnt <= '0;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_and_delay_checker.sv
// Directed bench for and_delay_checker: a fake delayed-AND DUT, a cycle-indexed golden
// model checked every cycle, and literal expectations at the end of each scenario.
`timescale 1ns/1ps
module tb_and_delay_checker;
    localparam int DELAY = 2;
    localparam int CNT_W = 16;
    localparam int SAT_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic dut_out = 1'b0;
    logic busy, mismatch, err;
    logic [CNT_W-1:0] chk_cnt, err_cnt;
    logic s_busy, s_mismatch, s_err;
    logic [SAT_W-1:0] s_chk_cnt, s_err_cnt;
`ifdef AND_DELAY_LAT_MEAS_EN
    logic [3:0] lat_cyc, s_lat_cyc;
    logic lat_vld, s_lat_vld;
`endif

    always #5 clk = ~clk;

    and_delay_checker #(.DELAY(DELAY), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .dut_out(dut_out),
        .busy(busy), .mismatch(mismatch), .err(err),
        .chk_cnt(chk_cnt), .err_cnt(err_cnt)
`ifdef AND_DELAY_LAT_MEAS_EN
        , .lat_cyc(lat_cyc), .lat_vld(lat_vld)
`endif
    );

    and_delay_checker #(.DELAY(DELAY), .CNT_W(SAT_W)) u_sat (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .dut_out(dut_out),
        .busy(s_busy), .mismatch(s_mismatch), .err(s_err),
        .chk_cnt(s_chk_cnt), .err_cnt(s_err_cnt)
`ifdef AND_DELAY_LAT_MEAS_EN
        , .lat_cyc(s_lat_cyc), .lat_vld(s_lat_vld)
`endif
    );

    int n_tests = 0;
    int n_fail = 0;
    int n_pulse = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int satv(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Fake DUT: delayed AND with selectable latency, stuck-at-0 and one-shot dropout.
    int cyc = 0;
    bit hist[0:4095];
    int dly = 2;
    bit stuck = 1'b0;

    task automatic step(input bit ia, input bit ib, input bit ien, input bit force0 = 1'b0);
        @(negedge clk);
        a = ia;
        b = ib;
        en = ien;
        hist[cyc] = ia & ib;
        dut_out = (stuck || force0) ? 1'b0 : ((cyc >= dly) ? hist[cyc - dly] : 1'b0);
        cyc++;
        @(posedge clk);
        #3;
    endtask

    // Golden model: a run starts at edge k0; every edge k >= k0+DELAY compares against sample k-DELAY.
    int mk = 0;
    bit mh[0:4095];
    bit m_run, m_busy, m_mis, m_err, m_lvld;
    int m_k0, m_chk, m_errc, m_ls, m_lcyc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_busy = 0; m_mis = 0; m_err = 0; m_chk = 0; m_errc = 0;
            m_ls = -1; m_lcyc = 0; m_lvld = 0;
        end else begin
            mh[mk] = a & b;
            m_mis = 0;
            if (!en) begin
                m_run = 0; m_busy = 0; m_ls = -1;
            end else if (!m_run) begin
                m_run = 1; m_busy = 1; m_k0 = mk; m_err = 0; m_chk = 0; m_errc = 0;
                m_ls = -1; m_lcyc = 0; m_lvld = 0;
            end else if (mk - m_k0 >= DELAY) begin
                m_chk++;
                if (dut_out !== mh[mk - DELAY]) begin
                    m_errc++; m_mis = 1; m_err = 1;
                end
                if (m_ls >= 0) begin
                    if (dut_out) begin
                        m_lcyc = mk - m_ls; m_lvld = 1; m_ls = -1;
                    end else if (mk - m_ls == 15) begin
                        m_lcyc = 15; m_lvld = 1; m_ls = -1;
`ifdef AND_DELAY_LAT_MEAS_EN
                        m_err = 1;
`endif
                    end
                end else if (!m_lvld && mh[mk] && !mh[mk - 1]) begin
                    m_ls = mk;
                end
            end
            mk++;
        end
    end

    always @(posedge clk) begin
        #2;
        if (!rst) begin
            check("busy", busy, m_busy);
            check("mismatch", mismatch, m_mis);
            check("err", err, m_err);
            check("chk_cnt", chk_cnt, satv(m_chk, CNT_W));
            check("err_cnt", err_cnt, satv(m_errc, CNT_W));
            check("sat_busy", s_busy, m_busy);
            check("sat_mismatch", s_mismatch, m_mis);
            check("sat_err", s_err, m_err);
            check("sat_chk_cnt", s_chk_cnt, satv(m_chk, SAT_W));
            check("sat_err_cnt", s_err_cnt, satv(m_errc, SAT_W));
`ifdef AND_DELAY_LAT_MEAS_EN
            check("lat_cyc", lat_cyc, m_lcyc);
            check("lat_vld", lat_vld, m_lvld);
            check("sat_lat_cyc", s_lat_cyc, m_lcyc);
            check("sat_lat_vld", s_lat_vld, m_lvld);
`endif
            n_pulse += int'(mismatch);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int p0;
        rst = 1'b1;
        repeat (2) step(0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_chk_cnt", chk_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);

        // Clean run: 36 steps, 34 compares.
        p0 = n_pulse;
        step(0, 0, 1); step(1, 0, 1); step(1, 1, 1); step(0, 1, 1);
        repeat (8) step(0, 0, 1);
        repeat (8) begin
            step(1, 0, 1); step(1, 1, 1); step(0, 1, 1);
        end
        check("clean_chk_cnt", chk_cnt, 34);
        check("clean_err_cnt", err_cnt, 0);
        check("clean_err", err, 0);
        check("clean_pulses", n_pulse - p0, 0);
        check("clean_sat_chk_cnt", s_chk_cnt, 3);

        // Single dropout while golden is 1.
        step(0, 0, 0);
        p0 = n_pulse;
        step(0, 0, 1); step(0, 0, 1); step(1, 1, 1); step(1, 1, 1);
        step(0, 0, 1, 1);
        check("fault_pulse", mismatch, 1);
        repeat (3) step(0, 0, 1);
        check("fault_err_cnt", err_cnt, 1);
        check("fault_err", err, 1);
        check("fault_pulses", n_pulse - p0, 1);
        check("fault_chk_cnt", chk_cnt, 6);

        // DUT one cycle late: each golden edge mismatches once.
        dly = 3;
        step(0, 0, 0);
        repeat (4) begin
            step(1, 0, 1); step(1, 1, 1); step(0, 1, 1);
        end
        check("late_err_cnt", err_cnt, 6);
        check("late_chk_cnt", chk_cnt, 10);
        check("late_err", err, 1);
        check("late_sat_err_cnt", s_err_cnt, 3);

        // Enable drop freezes results; re-enable clears them.
        dly = 2;
        step(0, 0, 0);
        check("drop_busy", busy, 0);
        check("drop_chk_cnt", chk_cnt, 10);
        check("drop_err_cnt", err_cnt, 6);
        check("drop_err", err, 1);
        step(0, 0, 0);
        check("drop_hold_chk_cnt", chk_cnt, 10);
        step(0, 0, 1);
        check("restart_chk_cnt", chk_cnt, 0);
        check("restart_err_cnt", err_cnt, 0);
        check("restart_err", err, 0);
        check("restart_busy", busy, 1);
        step(0, 0, 1);
        check("restart_k1_chk_cnt", chk_cnt, 0);
        step(0, 0, 1);
        check("restart_k2_chk_cnt", chk_cnt, 1);

        // Async reset between edges with err and mismatch high.
        step(1, 1, 1); step(0, 0, 1); step(0, 0, 1, 1);
        check("pre_rst_err", err, 1);
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_mismatch", mismatch, 0);
        check("arst_err", err, 0);
        check("arst_chk_cnt", chk_cnt, 0);
        check("arst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        step(0, 0, 0);
        check("post_rst_busy", busy, 0);
        step(0, 0, 1);
        check("post_rst_run_busy", busy, 1);
        check("post_rst_run_chk_cnt", chk_cnt, 0);

`ifdef AND_DELAY_LAT_MEAS_EN
        step(0, 0, 0);
        repeat (3) step(0, 0, 1);
        repeat (4) step(1, 1, 1);
        check("lat_clean_cyc", lat_cyc, 2);
        check("lat_clean_vld", lat_vld, 1);
        step(0, 0, 0);
        stuck = 1'b1;
        repeat (3) step(0, 0, 1);
        repeat (18) step(1, 1, 1);
        check("lat_stuck_cyc", lat_cyc, 15);
        check("lat_stuck_vld", lat_vld, 1);
        check("lat_stuck_err", err, 1);
        stuck = 1'b0;
`endif

        step(0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
